// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory sequencer: opcodes, FSM encoding,
// per-operation beat counts and the default stack pointer reset value.
package data_mem_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 16;
    localparam int SP_RESET_DEF = 2047;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDD  = 3'b001;
    localparam logic [2:0] OP_STD  = 3'b010;
    localparam logic [2:0] OP_PUSH = 3'b011;
    localparam logic [2:0] OP_POP  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_RTI  = 3'b111;

    // Internal micro-op: {is_int, op_code}
    localparam logic [3:0] UOP_LDD  = {1'b0, OP_LDD};
    localparam logic [3:0] UOP_STD  = {1'b0, OP_STD};
    localparam logic [3:0] UOP_PUSH = {1'b0, OP_PUSH};
    localparam logic [3:0] UOP_POP  = {1'b0, OP_POP};
    localparam logic [3:0] UOP_CALL = {1'b0, OP_CALL};
    localparam logic [3:0] UOP_RET  = {1'b0, OP_RET};
    localparam logic [3:0] UOP_RTI  = {1'b0, OP_RTI};
    localparam logic [3:0] UOP_INT  = 4'b1000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BEAT = 1'b1;

    // Index of the final beat for a micro-op (beat count minus one)
    function automatic logic [1:0] last_beat(input logic [3:0] uop);
        logic [1:0] r;
        r = 2'd0;
        case (uop)
            UOP_CALL, UOP_RET: r = 2'd1;
            UOP_RTI, UOP_INT:  r = 2'd2;
            default:           r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_sequencer_stack_pointer.sv
// Stack pointer register with modulo decrement/increment and wrap detection.
module stack_pointer #(
    parameter int ADDR_W   = 12,
    parameter int SP_RESET = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic              wrap
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + 1'b1;
    assign wrap     = (push && (sp_q == '0)) || (pop && (sp_q == '1));

    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q - 1'b1;
        end else if (pop) begin
            sp_d = sp_plus1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= ADDR_W'(SP_RESET);
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/data_mem_sequencer.sv
// Multi-cycle data memory sequencer: turns LDD/STD/stack/CALL/RET/INT/RTI
// commands into single-word memory beats and returns restored state.
module data_mem_sequencer
    import data_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SP_RESET = SP_RESET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    output logic              op_ready,
    input  logic              int_req,
    output logic              int_ack,
    input  logic [ADDR_W-1:0] eff_addr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        ccr_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              stall,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              pc_load,
    output logic [31:0]       pc_restore,
    output logic              ccr_load,
    output logic [2:0]        ccr_restore,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_err
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0]        uop_q, uop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [31:0]       pc_q, pc_d;
    logic [2:0]        ccr_q, ccr_d;
    logic [15:0]       pc_lo_q, pc_lo_d;
    logic [2:0]        ccr_tmp_q, ccr_tmp_d;
    logic              ld_valid_q, ld_valid_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              pc_load_q, pc_load_d;
    logic [31:0]       pc_restore_q, pc_restore_d;
    logic              ccr_load_q, ccr_load_d;
    logic [2:0]        ccr_restore_q, ccr_restore_d;
    logic              int_ack_q, int_ack_d;
    logic              stack_err_q, stack_err_d;

    logic              idle;
    logic              last;
    logic              start;
    logic              push;
    logic              pop;
    logic              wrap;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_plus1;

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .sp       (sp),
        .sp_plus1 (sp_plus1),
        .wrap     (wrap)
    );

    assign idle        = (state_q == ST_IDLE);
    assign last        = (beat_q == last_beat(uop_q));
    assign op_ready    = idle && !int_req;
    assign stall       = !idle || int_req;
    assign int_ack     = int_ack_q;
    assign ld_valid    = ld_valid_q;
    assign ld_data     = ld_data_q;
    assign pc_load     = pc_load_q;
    assign pc_restore  = pc_restore_q;
    assign ccr_load    = ccr_load_q;
    assign ccr_restore = ccr_restore_q;
    assign sp_out      = sp;
    assign stack_err   = stack_err_q;

    // Beat decode: memory strobes and SP moves come straight from state
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = sp;
        mem_wdata = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!idle) begin
            case (uop_q)
                UOP_LDD: begin
                    mem_rd   = 1'b1;
                    mem_addr = addr_q;
                end
                UOP_STD: begin
                    mem_wr    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = alu_q;
                end
                UOP_PUSH: begin
                    push      = 1'b1;
                    mem_wdata = alu_q;
                end
                UOP_CALL: begin
                    push      = 1'b1;
                    mem_wdata = (beat_q == 2'd0) ? DATA_W'(pc_q[31:16])
                                                 : DATA_W'(pc_q[15:0]);
                end
                UOP_INT: begin
                    push = 1'b1;
                    case (beat_q)
                        2'd0:    mem_wdata = DATA_W'(pc_q[31:16]);
                        2'd1:    mem_wdata = DATA_W'(pc_q[15:0]);
                        default: mem_wdata = DATA_W'(ccr_q);
                    endcase
                end
                UOP_POP, UOP_RET, UOP_RTI: pop = 1'b1;
                default: ;
            endcase
        end
        if (push) begin
            mem_wr   = 1'b1;
            mem_addr = sp;
        end
        if (pop) begin
            mem_rd   = 1'b1;
            mem_addr = sp_plus1;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        uop_d         = uop_q;
        addr_d        = addr_q;
        alu_d         = alu_q;
        pc_d          = pc_q;
        ccr_d         = ccr_q;
        pc_lo_d       = pc_lo_q;
        ccr_tmp_d     = ccr_tmp_q;
        ld_data_d     = ld_data_q;
        pc_restore_d  = pc_restore_q;
        ccr_restore_d = ccr_restore_q;
        ld_valid_d    = 1'b0;
        pc_load_d     = 1'b0;
        ccr_load_d    = 1'b0;
        int_ack_d     = 1'b0;
        start         = 1'b0;
        stack_err_d   = stack_err_q || wrap;
        if (idle) begin
            if (int_req) begin
                uop_d     = UOP_INT;
                int_ack_d = 1'b1;
                start     = 1'b1;
            end else if (op_valid && (op_code != OP_NOP)) begin
                uop_d = {1'b0, op_code};
                start = 1'b1;
            end
            if (start) begin
                state_d = ST_BEAT;
                beat_d  = 2'd0;
                addr_d  = eff_addr;
                alu_d   = alu_out;
                pc_d    = pc_in;
                ccr_d   = ccr_in;
            end
        end else begin
            beat_d = beat_q + 2'd1;
            if (last) begin
                state_d = ST_IDLE;
            end
            // Pops return low PC half before high; RTI pops CCR first
            case (uop_q)
                UOP_LDD, UOP_POP: begin
                    ld_valid_d = 1'b1;
                    ld_data_d  = mem_rdata;
                end
                UOP_RET, UOP_RTI: begin
                    if (last) begin
                        pc_load_d    = 1'b1;
                        pc_restore_d = {mem_rdata[15:0], pc_lo_q};
                        if (uop_q == UOP_RTI) begin
                            ccr_load_d    = 1'b1;
                            ccr_restore_d = ccr_tmp_q;
                        end
                    end else if ((uop_q == UOP_RTI) && (beat_q == 2'd0)) begin
                        ccr_tmp_d = mem_rdata[2:0];
                    end else begin
                        pc_lo_d = mem_rdata[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= 2'd0;
            uop_q         <= 4'd0;
            addr_q        <= '0;
            alu_q         <= '0;
            pc_q          <= 32'd0;
            ccr_q         <= 3'd0;
            pc_lo_q       <= 16'd0;
            ccr_tmp_q     <= 3'd0;
            ld_valid_q    <= 1'b0;
            ld_data_q     <= '0;
            pc_load_q     <= 1'b0;
            pc_restore_q  <= 32'd0;
            ccr_load_q    <= 1'b0;
            ccr_restore_q <= 3'd0;
            int_ack_q     <= 1'b0;
            stack_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            uop_q         <= uop_d;
            addr_q        <= addr_d;
            alu_q         <= alu_d;
            pc_q          <= pc_d;
            ccr_q         <= ccr_d;
            pc_lo_q       <= pc_lo_d;
            ccr_tmp_q     <= ccr_tmp_d;
            ld_valid_q    <= ld_valid_d;
            ld_data_q     <= ld_data_d;
            pc_load_q     <= pc_load_d;
            pc_restore_q  <= pc_restore_d;
            ccr_load_q    <= ccr_load_d;
            ccr_restore_q <= ccr_restore_d;
            int_ack_q     <= int_ack_d;
            stack_err_q   <= stack_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer with a behavioural word memory.
module tb_data_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_ready;
    logic        int_req;
    logic        int_ack;
    logic [11:0] eff_addr;
    logic [15:0] alu_out;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        stall;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        pc_load;
    logic [31:0] pc_restore;
    logic        ccr_load;
    logic [2:0]  ccr_restore;
    logic [11:0] sp_out;
    logic        stack_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int wc;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    data_mem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .eff_addr    (eff_addr),
        .alu_out     (alu_out),
        .pc_in       (pc_in),
        .ccr_in      (ccr_in),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .pc_load     (pc_load),
        .pc_restore  (pc_restore),
        .ccr_load    (ccr_load),
        .ccr_restore (ccr_restore),
        .sp_out      (sp_out),
        .stack_err   (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'b000;
        int_req  = 1'b0;
        eff_addr = 12'd0;
        alu_out  = 16'd0;
        pc_in    = 32'd0;
        ccr_in   = 3'd0;
        tick();
        tick();
        chk("rst_sp", sp_out, 2047);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_strobes", {ld_valid, pc_load, ccr_load, int_ack}, 0);
        chk("rst_data", {ld_data, ccr_restore}, 0);
        chk("rst_pc", pc_restore, 0);
        chk("rst_err", stack_err, 0);
        rst = 1'b0;
        tick();

        // NOP stays idle
        op_valid = 1'b1;
        op_code  = 3'b000;
        tick();
        op_valid = 1'b0;
        #1;
        chk("nop_stall", stall, 0);
        chk("nop_rd_wr", {mem_rd, mem_wr}, 0);

        // PUSH 0xBEEF
        op_valid = 1'b1;
        op_code  = 3'b011;
        alu_out  = 16'hBEEF;
        #1;
        chk("push_ready_n", op_ready, 1);
        tick();
        op_valid = 1'b0;
        alu_out  = 16'h0000;
        #1;
        chk("push_ready_b", op_ready, 0);
        chk("push_wr", {mem_wr, mem_rd}, 2'b10);
        chk("push_addr", mem_addr, 2047);
        chk("push_wdata", mem_wdata, 16'hBEEF);
        tick();
        chk("push_ready_i", op_ready, 1);
        chk("push_sp", sp_out, 2046);
        chk("push_mem", mem[2047], 16'hBEEF);
        chk("push_idle_wr", mem_wr, 0);

        // POP
        op_valid = 1'b1;
        op_code  = 3'b100;
        tick();
        op_valid = 1'b0;
        #1;
        chk("pop_rd", {mem_rd, mem_wr}, 2'b10);
        chk("pop_addr", mem_addr, 2047);
        chk("pop_ready_b", op_ready, 0);
        tick();
        chk("pop_ldv", ld_valid, 1);
        chk("pop_ldd", ld_data, 16'hBEEF);
        chk("pop_sp", sp_out, 2047);
        tick();
        chk("pop_ldv_off", ld_valid, 0);

        // CALL 0x0001_0234
        op_valid = 1'b1;
        op_code  = 3'b101;
        pc_in    = 32'h0001_0234;
        tick();
        op_valid = 1'b0;
        pc_in    = 32'hFFFF_FFFF;
        #1;
        chk("call_b0_wr", mem_wr, 1);
        chk("call_b0_addr", mem_addr, 2047);
        chk("call_b0_data", mem_wdata, 16'h0001);
        tick();
        chk("call_b1_addr", mem_addr, 2046);
        chk("call_b1_data", mem_wdata, 16'h0234);
        tick();
        chk("call_idle", stall, 0);
        chk("call_sp", sp_out, 2045);
        chk("call_m2047", mem[2047], 16'h0001);
        chk("call_m2046", mem[2046], 16'h0234);

        // RET
        op_valid = 1'b1;
        op_code  = 3'b110;
        tick();
        op_valid = 1'b0;
        #1;
        chk("ret_b0_addr", mem_addr, 2046);
        chk("ret_b0_rd", mem_rd, 1);
        tick();
        chk("ret_b1_addr", mem_addr, 2047);
        chk("ret_b1_pcl", pc_load, 0);
        tick();
        chk("ret_pcl", pc_load, 1);
        chk("ret_pc", pc_restore, 32'h0001_0234);
        chk("ret_ccrl", ccr_load, 0);
        chk("ret_sp", sp_out, 2047);
        tick();
        chk("ret_pcl_off", pc_load, 0);

        // INT and STD together: INT wins, STD follows
        int_req  = 1'b1;
        op_valid = 1'b1;
        op_code  = 3'b010;
        eff_addr = 12'h020;
        alu_out  = 16'h5A5A;
        pc_in    = 32'h0000_0040;
        ccr_in   = 3'b101;
        #1;
        chk("int_ready", op_ready, 0);
        chk("int_stall", stall, 1);
        tick();
        int_req = 1'b0;
        pc_in   = 32'hFFFF_FFFF;
        ccr_in  = 3'b000;
        #1;
        chk("int_ack", int_ack, 1);
        chk("int_b0_addr", mem_addr, 2047);
        chk("int_b0_data", mem_wdata, 16'h0000);
        tick();
        chk("int_ack_off", int_ack, 0);
        chk("int_b1_addr", mem_addr, 2046);
        chk("int_b1_data", mem_wdata, 16'h0040);
        tick();
        chk("int_b2_addr", mem_addr, 2045);
        chk("int_b2_data", mem_wdata, 16'h0005);
        chk("int_b2_wr", mem_wr, 1);
        tick();
        chk("int_done_sp", sp_out, 2044);
        chk("int_std_ready", op_ready, 1);
        chk("int_done_wr", mem_wr, 0);
        tick();
        op_valid = 1'b0;
        #1;
        chk("std_wr", {mem_wr, mem_rd}, 2'b10);
        chk("std_addr", mem_addr, 12'h020);
        chk("std_data", mem_wdata, 16'h5A5A);
        tick();
        chk("std_sp", sp_out, 2044);
        chk("std_mem", mem[12'h020], 16'h5A5A);

        // RTI
        op_valid = 1'b1;
        op_code  = 3'b111;
        tick();
        op_valid = 1'b0;
        #1;
        chk("rti_b0_addr", mem_addr, 2045);
        tick();
        chk("rti_b1_addr", mem_addr, 2046);
        tick();
        chk("rti_b2_addr", mem_addr, 2047);
        chk("rti_b2_load", {pc_load, ccr_load}, 0);
        tick();
        chk("rti_loads", {pc_load, ccr_load}, 2'b11);
        chk("rti_ccr", ccr_restore, 3'b101);
        chk("rti_pc", pc_restore, 32'h0000_0040);
        chk("rti_sp", sp_out, 2047);

        // STD 0x1234 to 0x010 then LDD it back
        op_valid = 1'b1;
        op_code  = 3'b010;
        eff_addr = 12'h010;
        alu_out  = 16'h1234;
        tick();
        op_valid = 1'b0;
        tick();
        op_valid = 1'b1;
        op_code  = 3'b001;
        alu_out  = 16'h0000;
        tick();
        op_valid = 1'b0;
        eff_addr = 12'h000;
        #1;
        chk("ldd_rd", {mem_rd, mem_wr}, 2'b10);
        chk("ldd_addr", mem_addr, 12'h010);
        chk("ldd_sp_b", sp_out, 2047);
        tick();
        chk("ldd_rd_off", mem_rd, 0);
        chk("ldd_ldv", ld_valid, 1);
        chk("ldd_data", ld_data, 16'h1234);
        chk("ldd_sp", sp_out, 2047);

        // Walk SP up to 4095 with 2048 pops, then wrap
        op_valid = 1'b1;
        op_code  = 3'b100;
        repeat (4095) tick();
        op_valid = 1'b0;
        tick();
        chk("walk_sp", sp_out, 4095);
        chk("walk_err", stack_err, 0);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        #1;
        chk("wrap_addr", mem_addr, 0);
        tick();
        chk("wrap_sp", sp_out, 0);
        chk("wrap_err", stack_err, 1);

        // INT aborted by reset during its second beat
        int_req = 1'b1;
        pc_in   = 32'h1234_5678;
        ccr_in  = 3'b111;
        tick();
        int_req = 1'b0;
        #1;
        chk("abort_b0_addr", mem_addr, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_b1_wr", mem_wr, 1);
        chk("abort_b1_addr", mem_addr, 4095);
        chk("abort_err_held", stack_err, 1);
        tick();
        wc  = wr_cnt;
        rst = 1'b0;
        #1;
        chk("abort_sp", sp_out, 2047);
        chk("abort_err", stack_err, 0);
        chk("abort_wr", mem_wr, 0);
        chk("abort_stall", stall, 0);
        tick();
        tick();
        chk("abort_no_write", wr_cnt, wc);
        chk("abort_m0", mem[0], 16'h1234);
        chk("abort_m4095", mem[4095], 16'h5678);
        chk("abort_sp2", sp_out, 2047);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
